// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state encoding, default sizes and width formulas for sum_accumulator
package sum_acc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_BATCH  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_t;

    // Room for the carry bit plus log2(BATCH) bits of growth, so the total never wraps.
    function automatic int acc_width(input int data_w, input int batch);
        return data_w + 1 + $clog2(batch);
    endfunction

    function automatic int cnt_width(input int batch);
        return $clog2(batch) + 1;
    endfunction

endpackage

// File: rtl/sum_accumulator_sample_counter.sv
// rtl/sum_accumulator_sample_counter.sv - clearable, enabled up-counter with a BATCH-1 terminal flag
module sample_counter
    import sum_acc_pkg::*;
#(
    parameter int CNT_W = cnt_width(DEF_BATCH),
    parameter int BATCH = DEF_BATCH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             En,
    output logic [CNT_W-1:0] Count,
    output logic             Terminal
);

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            Count <= '0;
        end else if (En) begin
            Count <= Count + CNT_W'(1);
        end
    end

    assign Terminal = (Count == CNT_W'(BATCH - 1));

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - batch accumulator of adder results with Done/Ack handshake
// Optional overflow-sample counter built when SUM_ACCUMULATOR_OVF_CNT_EN is defined.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int BATCH  = DEF_BATCH,
    localparam int ACC_W  = acc_width(DATA_W, BATCH),
    localparam int CNT_W  = cnt_width(BATCH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] Sum,
    input  logic              Overflow,
    input  logic              Ack,
    output logic              Busy,
    output logic              Done,
    output logic [ACC_W-1:0]  Acc,
    output logic [CNT_W-1:0]  Ovf_Count
);

    state_t           state;
    state_t           state_nxt;
    logic             batch_clear;
    logic             accept;
    logic             batch_last;
    logic [CNT_W-1:0] batch_count_unused;

    assign batch_clear = (state == S_IDLE) && Start;
    assign accept      = (state == S_ACCUM) && In_Valid;

    sample_counter #(
        .CNT_W (CNT_W),
        .BATCH (BATCH)
    ) u_batch_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (batch_clear),
        .En       (accept),
        .Count    (batch_count_unused),
        .Terminal (batch_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                Busy = 1'b1;
                if (accept && batch_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                if (Ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The carry-out is the top bit of the addend, so each sample is worth up to 2^(DATA_W+1)-2.
    always_ff @(posedge Clk) begin
        if (Reset || batch_clear) begin
            Acc <= '0;
        end else if (accept) begin
            Acc <= Acc + ACC_W'({Overflow, Sum});
        end
    end

`ifdef SUM_ACCUMULATOR_OVF_CNT_EN
    logic ovf_term_unused;

    sample_counter #(
        .CNT_W (CNT_W),
        .BATCH (BATCH)
    ) u_ovf_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (batch_clear),
        .En       (accept && Overflow),
        .Count    (Ovf_Count),
        .Terminal (ovf_term_unused)
    );
`else
    assign Ovf_Count = '0;
`endif

endmodule
